// File: rtl/tiny_alu_pkg.sv
// Shared types for the tiny ALU and its command issuer: opcode encoding and
// issuer FSM states.
package tiny_alu_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } issuer_state_e;

  localparam int OPCODE_BITS = 3;

endpackage

// File: rtl/tiny_alu_cmd_fifo.sv
// Synchronous FIFO for queued ALU commands; DEPTH must be a power of 2 so
// the pointers wrap naturally.
module tiny_alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [LVL_BITS-1:0] level;
  logic                do_push;
  logic                do_pop;

  assign full_o  = (level == LVL_BITS'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign rdata_o = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset; only the pointers and level define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tiny_alu_cmd_issuer.sv
// Buffers ALU commands, issues them one at a time on the start/done bus and
// returns result plus tag on a response stream, with a per-command watchdog.
module tiny_alu_cmd_issuer
  import tiny_alu_pkg::*;
#(
  parameter int INPUT_DATA_BITS = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int TAG_BITS        = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [2:0]                     cmd_opcode_i,
  input  logic [INPUT_DATA_BITS-1:0]     cmd_a_i,
  input  logic [INPUT_DATA_BITS-1:0]     cmd_b_i,
  input  logic [TAG_BITS-1:0]            cmd_tag_i,
  output logic                           alu_start_o,
  output logic [2:0]                     alu_opcode_o,
  output logic [INPUT_DATA_BITS-1:0]     alu_a_o,
  output logic [INPUT_DATA_BITS-1:0]     alu_b_o,
  input  logic                           alu_done_i,
  input  logic [2*INPUT_DATA_BITS-1:0]   alu_result_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [2*INPUT_DATA_BITS-1:0]   rsp_result_o,
  output logic [2:0]                     rsp_opcode_o,
  output logic [TAG_BITS-1:0]            rsp_tag_o,
  output logic                           rsp_timeout_o,
  output logic                           busy_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

  localparam int DW      = INPUT_DATA_BITS;
  localparam int RW      = 2 * INPUT_DATA_BITS;
  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic [OPCODE_BITS-1:0] opcode;
    logic [DW-1:0]          a;
    logic [DW-1:0]          b;
    logic [TAG_BITS-1:0]    tag;
  } cmd_t;

  issuer_state_e        state;
  cmd_t                 push_cmd;
  cmd_t                 head_cmd;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [WD_BITS-1:0]   watchdog;
  logic [TAG_BITS-1:0]  issue_tag;

  assign push_cmd    = '{opcode: cmd_opcode_i, a: cmd_a_i, b: cmd_b_i, tag: cmd_tag_i};
  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;
  assign busy_o      = (state != ST_IDLE) || !fifo_empty;

  tiny_alu_cmd_fifo #(
    .WIDTH($bits(cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_cmd),
    .rdata_o (head_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  // done is only honoured in ISSUE, so the ALU's late trailing done pulse
  // after start drops falls into RESP or IDLE and is discarded.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      watchdog      <= '0;
      issue_tag     <= '0;
      alu_start_o   <= 1'b0;
      alu_opcode_o  <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_result_o  <= '0;
      rsp_opcode_o  <= '0;
      rsp_tag_o     <= '0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_opcode_o <= head_cmd.opcode;
            alu_a_o      <= head_cmd.a;
            alu_b_o      <= head_cmd.b;
            issue_tag    <= head_cmd.tag;
            alu_start_o  <= 1'b1;
            watchdog     <= '0;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (alu_done_i) begin
            rsp_result_o  <= alu_result_i;
            rsp_timeout_o <= 1'b0;
            rsp_opcode_o  <= alu_opcode_o;
            rsp_tag_o     <= issue_tag;
            rsp_valid_o   <= 1'b1;
            alu_start_o   <= 1'b0;
            state         <= ST_RESP;
          end else if (watchdog == WD_LAST) begin
            rsp_result_o  <= RW'(0);
            rsp_timeout_o <= 1'b1;
            rsp_opcode_o  <= alu_opcode_o;
            rsp_tag_o     <= issue_tag;
            rsp_valid_o   <= 1'b1;
            alu_start_o   <= 1'b0;
            state         <= ST_RESP;
          end else begin
            watchdog <= watchdog + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          alu_start_o <= 1'b0;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
